// File: rtl/sc_wordpacker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sc_wordpacker_pkg
//  Purpose  : Shared definitions for the sc_wordpacker byte-to-word assembler.
//             Holds the packer state encoding and the byte lane width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sc_wordpacker_pkg;

   // Width of one incoming byte lane.
   localparam int unsigned C_BYTE_W = 8;

   // Packer control states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_LOAD    = 2'd2
   } wp_state_e;

endpackage : sc_wordpacker_pkg
`default_nettype wire

// File: rtl/sc_wordpacker_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sc_wordpacker_timer
//  Purpose  : Saturating idle-cycle counter. Counts every cycle in which
//             clear_i is low, holds at TIMEOUT, and flags expiry while the
//             count equals TIMEOUT.
//  Ports    : clk_i      - clock, rising edge
//             rst_i      - synchronous active-high reset
//             clear_i    - restart the count from zero at the next edge
//             expired_o  - count has reached TIMEOUT
//  Revision : 1.0  initial release
// ============================================================================
module sc_wordpacker_timer #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int unsigned C_CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT);

   logic [C_CNT_W-1:0] count_q;
   logic [C_CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_q != C_LIMIT) begin
         // Saturate at the limit so a long stall never wraps back to zero.
         count_d = count_q + C_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == C_LIMIT);

endmodule : sc_wordpacker_timer
`default_nettype wire

// File: rtl/sc_wordpacker.sv
`default_nettype none
// ============================================================================
//  Module   : sc_wordpacker
//  Purpose  : Packs a valid/ready byte stream big-endian into one
//             WORDPACKER_DATAWIDTH-bit word and issues a one-cycle active-low
//             load strobe to the downstream register stage.
//  Ports    : SC_WORDPACKER_CLOCK_50        - clock, rising edge
//             SC_WORDPACKER_RESET_InHigh    - synchronous active-high reset
//             SC_WORDPACKER_byte_InBus      - incoming byte
//             SC_WORDPACKER_valid_InHigh    - incoming byte valid
//             SC_WORDPACKER_ready_OutHigh   - byte can be accepted this cycle
//             SC_WORDPACKER_data_OutBus     - last completed word (registered)
//             SC_WORDPACKER_load_OutLow     - one-cycle load strobe, active low
//             SC_WORDPACKER_timeout_OutHigh - one-cycle partial-word discard
//  Config   : define WORDPACKER_TIMEOUT_EN to build the inter-byte timeout;
//             otherwise COLLECT waits indefinitely and timeout is tied low.
//             WORDPACKER_DATAWIDTH must be a multiple of 8 and at least 16.
//  Revision : 1.0  initial release
// ============================================================================
module sc_wordpacker
   import sc_wordpacker_pkg::*;
#(
   parameter int unsigned WORDPACKER_DATAWIDTH = 32,
   parameter int unsigned WORDPACKER_TIMEOUT   = 1000
) (
   input  logic                            SC_WORDPACKER_CLOCK_50,
   input  logic                            SC_WORDPACKER_RESET_InHigh,
   input  logic [C_BYTE_W-1:0]             SC_WORDPACKER_byte_InBus,
   input  logic                            SC_WORDPACKER_valid_InHigh,
   output logic                            SC_WORDPACKER_ready_OutHigh,
   output logic [WORDPACKER_DATAWIDTH-1:0] SC_WORDPACKER_data_OutBus,
   output logic                            SC_WORDPACKER_load_OutLow,
   output logic                            SC_WORDPACKER_timeout_OutHigh
);

   localparam int unsigned C_W     = WORDPACKER_DATAWIDTH;
   localparam int unsigned C_N     = C_W / C_BYTE_W;
   localparam int unsigned C_CNT_W = $clog2(C_N) + 1;
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_N - 1);

   wp_state_e           state_q, state_d;
   logic [C_CNT_W-1:0]  count_q, count_d;
   logic [C_W-1:0]      shift_q, shift_d;
   logic [C_W-1:0]      data_q,  data_d;
   logic                load_n_q, load_n_d;
   logic                timeout_q, timeout_d;

   logic                w_accept;
   logic                w_expired;
   logic [C_W-1:0]      w_shifted;

   // Ready depends on state only, so there is no combinational path from
   // valid back to ready.
   assign SC_WORDPACKER_ready_OutHigh = (state_q != ST_LOAD);
   assign w_accept  = SC_WORDPACKER_valid_InHigh & SC_WORDPACKER_ready_OutHigh;
   assign w_shifted = {shift_q[C_W-C_BYTE_W-1:0], SC_WORDPACKER_byte_InBus};

`ifdef WORDPACKER_TIMEOUT_EN
   sc_wordpacker_timer #(
      .TIMEOUT   (WORDPACKER_TIMEOUT)
   ) u_timer (
      .clk_i     (SC_WORDPACKER_CLOCK_50),
      .rst_i     (SC_WORDPACKER_RESET_InHigh),
      .clear_i   (w_accept | (state_q != ST_COLLECT)),
      .expired_o (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      shift_d   = shift_q;
      data_d    = data_q;
      load_n_d  = 1'b1;
      timeout_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               // Widths of 16 and up mean the first byte never completes a word.
               shift_d = w_shifted;
               count_d = C_CNT_W'(1);
               state_d = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            // An accept in the same cycle as expiry takes priority.
            if (w_accept) begin
               if (count_q == C_LAST) begin
                  data_d   = w_shifted;
                  load_n_d = 1'b0;
                  shift_d  = '0;
                  count_d  = '0;
                  state_d  = ST_LOAD;
               end else begin
                  shift_d = w_shifted;
                  count_d = count_q + C_CNT_W'(1);
               end
            end else if (w_expired) begin
               shift_d   = '0;
               count_d   = '0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end

         ST_LOAD: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            count_d = '0;
            shift_d = '0;
         end
      endcase
   end

   always_ff @(posedge SC_WORDPACKER_CLOCK_50) begin
      if (SC_WORDPACKER_RESET_InHigh) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         load_n_q  <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         load_n_q  <= load_n_d;
         timeout_q <= timeout_d;
      end
   end

   assign SC_WORDPACKER_data_OutBus     = data_q;
   assign SC_WORDPACKER_load_OutLow     = load_n_q;
   assign SC_WORDPACKER_timeout_OutHigh = timeout_q;

endmodule : sc_wordpacker
`default_nettype wire
